// File: rtl/mem_arbiter.sv
// Shares one RAM bus between instruction fetch and the load/store stage.
// One transaction at a time, wait-state handshake, watchdog abort.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TW      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        d_en,
   input  logic        d_we,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   input  logic        advance,
   output logic        bus_en,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err,
   input  logic        clr_err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_D,
      BUSY_I
   } state_e;

   localparam bit          WD_EN  = (TIMEOUT != 0);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          i_done_q, i_done_d;
   logic          d_done_q, d_done_d;
   logic          we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic          busy;
   logic          d_pend;
   logic          i_pend;
   logic          expire;
   logic          complete;
   logic          grant_d;
   logic          grant_i;
   logic [31:0]   rdata_in;

   always_comb begin
      state_d    = state_q;
      i_done_d   = i_done_q;
      d_done_d   = d_done_q;
      we_d       = we_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      grant_d    = 1'b0;
      grant_i    = 1'b0;

      busy     = (state_q != IDLE);
      d_pend   = d_en & ~d_done_q;
      i_pend   = if_ce & ~i_done_q;
      expire   = busy & ~bus_ack & WD_EN & (cnt_q == WD_LAST);
      complete = busy & (bus_ack | expire);
      // An aborted read returns zero rather than whatever floats on the bus
      rdata_in = bus_ack ? bus_rdata : 32'h0;

      if (advance) begin
         i_done_d = 1'b0;
         d_done_d = 1'b0;
      end

      if (clr_err)
         err_d = 1'b0;
      if (expire)
         err_d = 1'b1;

      if (busy & ~bus_ack)
         cnt_d = cnt_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (d_pend)
               grant_d = 1'b1;
            else if (i_pend)
               grant_i = 1'b1;
         end
         BUSY_D: begin
            if (complete) begin
               d_done_d = 1'b1;
               if (!we_q)
                  d_rdata_d = rdata_in;
               if (i_pend)
                  grant_i = 1'b1;
               else
                  state_d = IDLE;
            end
         end
         BUSY_I: begin
            if (complete) begin
               i_done_d   = 1'b1;
               if_rdata_d = rdata_in;
               if (d_pend)
                  grant_d = 1'b1;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_d) begin
         state_d = BUSY_D;
         we_d    = d_we;
         sel_d   = d_sel;
         addr_d  = d_addr;
         wdata_d = d_wdata;
         cnt_d   = '0;
      end

      if (grant_i) begin
         state_d = BUSY_I;
         we_d    = 1'b0;
         sel_d   = 4'b1111;
         addr_d  = if_addr;
         wdata_d = 32'h0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         i_done_q   <= 1'b0;
         d_done_q   <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= 4'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         if_rdata_q <= 32'h0;
         d_rdata_q  <= 32'h0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_done_q   <= i_done_d;
         d_done_q   <= d_done_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   // Bus side comes only from flops; requester inputs never reach it directly
   assign bus_en    = busy;
   assign bus_we    = busy & we_q;
   assign bus_sel   = busy ? sel_q : 4'h0;
   assign bus_addr  = busy ? addr_q : 32'h0;
   assign bus_wdata = busy ? wdata_q : 32'h0;
   assign bus_err   = err_q;

   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_stall  = rst & if_ce & ~i_done_q;
   assign d_stall   = rst & d_en & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, store wait states,
// watchdog abort and reset in the middle of a transaction.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_ce;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_en;
   logic        d_we;
   logic [3:0]  d_sel;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        advance;
   logic        bus_en;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;
   logic        clr_err;

   int checks;
   int failures;

   mem_arbiter #(
      .TIMEOUT(4),
      .TW     (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_ce    (if_ce),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_stall (if_stall),
      .d_en     (d_en),
      .d_we     (d_we),
      .d_sel    (d_sel),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_stall  (d_stall),
      .advance  (advance),
      .bus_en   (bus_en),
      .bus_we   (bus_we),
      .bus_sel  (bus_sel),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .bus_ack  (bus_ack),
      .bus_err  (bus_err),
      .clr_err  (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      if_ce     = 1'b0;
      if_addr   = 32'h0;
      d_en      = 1'b0;
      d_we      = 1'b0;
      d_sel     = 4'h0;
      d_addr    = 32'h0;
      d_wdata   = 32'h0;
      advance   = 1'b0;
      bus_rdata = 32'h0;
      bus_ack   = 1'b0;
      clr_err   = 1'b0;

      // reset: stalls forced low even with requests asserted
      tick();
      if_ce = 1'b1;
      d_en  = 1'b1;
      tick();
      chk("rst_bus_en", {31'h0, bus_en}, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst_if_stall", {31'h0, if_stall}, 32'h0);
      chk("rst_d_stall", {31'h0, d_stall}, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      if_ce = 1'b0;
      d_en  = 1'b0;
      rst   = 1'b1;
      tick();
      chk("idle_bus_en", {31'h0, bus_en}, 32'h0);

      // single fetch, cycle 0
      if_ce   = 1'b1;
      if_addr = 32'h100;
      #1;
      chk("f0_stall", {31'h0, if_stall}, 32'h1);
      chk("f0_bus_en", {31'h0, bus_en}, 32'h0);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h2401_0005;
      #1;
      chk("f1_bus_en", {31'h0, bus_en}, 32'h1);
      chk("f1_addr", bus_addr, 32'h100);
      chk("f1_sel", {28'h0, bus_sel}, 32'hF);
      chk("f1_we", {31'h0, bus_we}, 32'h0);
      chk("f1_stall", {31'h0, if_stall}, 32'h1);
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      advance   = 1'b1;
      #1;
      chk("f2_stall", {31'h0, if_stall}, 32'h0);
      chk("f2_rdata", if_rdata, 32'h2401_0005);
      chk("f2_bus_en", {31'h0, bus_en}, 32'h0);
      tick();
      advance = 1'b0;
      if_ce   = 1'b0;
      #1;
      chk("f3_noreissue", {31'h0, bus_en}, 32'h0);
      chk("f3_rdata_hold", if_rdata, 32'h2401_0005);
      tick();

      // contention: load and fetch in the same cycle
      d_en    = 1'b1;
      d_we    = 1'b0;
      d_sel   = 4'hF;
      d_addr  = 32'h200;
      if_ce   = 1'b1;
      if_addr = 32'h104;
      #1;
      chk("c0_d_stall", {31'h0, d_stall}, 32'h1);
      chk("c0_i_stall", {31'h0, if_stall}, 32'h1);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'hAAAA_5555;
      #1;
      chk("c1_addr", bus_addr, 32'h200);
      chk("c1_bus_en", {31'h0, bus_en}, 32'h1);
      tick();
      bus_rdata = 32'h8C02_0000;
      #1;
      chk("c2_addr", bus_addr, 32'h104);
      chk("c2_bus_en", {31'h0, bus_en}, 32'h1);
      chk("c2_d_stall", {31'h0, d_stall}, 32'h0);
      chk("c2_i_stall", {31'h0, if_stall}, 32'h1);
      chk("c2_d_rdata", d_rdata, 32'hAAAA_5555);
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      advance   = 1'b1;
      #1;
      chk("c3_i_stall", {31'h0, if_stall}, 32'h0);
      chk("c3_d_stall", {31'h0, d_stall}, 32'h0);
      chk("c3_if_rdata", if_rdata, 32'h8C02_0000);
      chk("c3_bus_en", {31'h0, bus_en}, 32'h0);
      tick();
      advance = 1'b0;
      #1;
      chk("c4_d_clr", {31'h0, d_stall}, 32'h1);
      chk("c4_i_clr", {31'h0, if_stall}, 32'h1);
      d_en  = 1'b0;
      if_ce = 1'b0;
      tick();

      // store with three wait cycles
      d_en    = 1'b1;
      d_we    = 1'b1;
      d_sel   = 4'b0011;
      d_addr  = 32'h40;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      for (int i = 1; i <= 4; i++) begin
         bus_ack = (i == 4);
         #1;
         chk($sformatf("s%0d_we", i), {31'h0, bus_we}, 32'h1);
         chk($sformatf("s%0d_sel", i), {28'h0, bus_sel}, 32'h3);
         chk($sformatf("s%0d_addr", i), bus_addr, 32'h40);
         chk($sformatf("s%0d_wdata", i), bus_wdata, 32'hDEAD_BEEF);
         chk($sformatf("s%0d_stall", i), {31'h0, d_stall}, 32'h1);
         tick();
      end
      bus_ack = 1'b0;
      #1;
      chk("s5_stall", {31'h0, d_stall}, 32'h0);
      chk("s5_d_rdata", d_rdata, 32'hAAAA_5555);
      chk("s5_bus_en", {31'h0, bus_en}, 32'h0);
      chk("s5_bus_we", {31'h0, bus_we}, 32'h0);
      advance = 1'b1;
      d_en    = 1'b0;
      d_we    = 1'b0;
      tick();
      advance = 1'b0;

      // watchdog: fetch that is never acknowledged
      if_ce   = 1'b1;
      if_addr = 32'h300;
      tick();
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("w%0d_bus_en", i), {31'h0, bus_en}, 32'h1);
         chk($sformatf("w%0d_err", i), {31'h0, bus_err}, 32'h0);
         tick();
      end
      #1;
      chk("w5_bus_en", {31'h0, bus_en}, 32'h0);
      chk("w5_err", {31'h0, bus_err}, 32'h1);
      chk("w5_if_rdata", if_rdata, 32'h0);
      chk("w5_stall", {31'h0, if_stall}, 32'h0);
      clr_err = 1'b1;
      advance = 1'b1;
      if_ce   = 1'b0;
      tick();
      clr_err = 1'b0;
      advance = 1'b0;
      #1;
      chk("w6_err_clr", {31'h0, bus_err}, 32'h0);
      tick();

      // reset in the middle of a waited load
      d_en   = 1'b1;
      d_we   = 1'b0;
      d_sel  = 4'hF;
      d_addr = 32'h500;
      tick();
      #1;
      chk("r1_bus_en", {31'h0, bus_en}, 32'h1);
      chk("r1_addr", bus_addr, 32'h500);
      tick();
      rst = 1'b0;
      #1;
      chk("r2_bus_en", {31'h0, bus_en}, 32'h0);
      chk("r2_addr", bus_addr, 32'h0);
      chk("r2_d_stall", {31'h0, d_stall}, 32'h0);
      chk("r2_d_rdata", d_rdata, 32'h0);
      chk("r2_if_rdata", if_rdata, 32'h0);
      tick();
      rst    = 1'b1;
      d_addr = 32'h504;
      #1;
      chk("r3_d_stall", {31'h0, d_stall}, 32'h1);
      chk("r3_bus_en", {31'h0, bus_en}, 32'h0);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      #1;
      chk("r4_bus_en", {31'h0, bus_en}, 32'h1);
      chk("r4_addr", bus_addr, 32'h504);
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      #1;
      chk("r5_d_stall", {31'h0, d_stall}, 32'h0);
      chk("r5_d_rdata", d_rdata, 32'h1234_5678);
      d_en = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one arbiter that shares the single unified RAM bus between the instruction-fetch path (pc/ce) and the memory-stage load/store path of the 5-stage MIPS pipeline. It sequences one bus transaction at a time with a wait-state handshake and latches returned read data. It raises per-requester stalls to the pipeline and releases them only when the requester's result is held and the pipeline advances. A watchdog aborts hung transactions.

## Interface
Parameters:
- TIMEOUT, 255, BUSY cycles without ack before abort; 0 disables watchdog
- TW, 8, watchdog counter width; TIMEOUT ≤ 2^TW−1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_ce  in  1  fetch request (level, held while if_stall)
- if_addr  in  32  fetch address
- if_rdata  out  32  latched fetch data
- if_stall  out  1  fetch not yet complete
- d_en  in  1  data request (level, held while d_stall)
- d_we  in  1  1 = store, 0 = load
- d_sel  in  4  byte lane select
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  latched load data
- d_stall  out  1  data access not yet complete
- advance  in  1  pipeline advances this cycle (global no-stall)
- bus_en  out  1  bus transaction active
- bus_we  out  1  write strobe
- bus_sel  out  4  byte lanes
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transaction complete
- bus_err  out  1  sticky watchdog error
- clr_err  in  1  clears bus_err

## Operation
- State: IDLE, BUSY_D, BUSY_I. Flags i_done, d_done. Registers for latched addr/we/sel/wdata, if_rdata, d_rdata, watchdog count.
- Pending: d_pend = d_en & !d_done; i_pend = if_ce & !i_done.
- Stalls (combinational from flags): if_stall = if_ce & !i_done; d_stall = d_en & !d_done.
- IDLE: d_pend → BUSY_D (latch d_addr, d_we, d_sel, d_wdata); else i_pend → BUSY_I (latch if_addr, we=0, sel=4'b1111, wdata=0); else stay. Data has priority (older instruction).
- BUSY_x: bus_en=1, bus_* from latched regs, held stable until completion. bus_en=0 and bus_* = 0 outside BUSY.
- Completion = bus_ack, or watchdog expiry. On completion: x_done←1; loads/fetches latch bus_rdata (0 on timeout) into x_rdata; stores leave d_rdata unchanged. Next state: other requester pending and not done → its BUSY directly (latch its request), else IDLE.
- advance=1 at an edge clears both done flags; if a completion coincides, that requester's done flag is set (set wins).
- Watchdog: cleared on entering BUSY, increments each BUSY cycle without ack; on reaching TIMEOUT (≠0) completes transaction, sets bus_err. bus_err cleared by clr_err; new error in same cycle wins.
- Reset (rst low, any time, including mid-transaction): state IDLE, flags/regs/counter 0, bus_en drops immediately; all outputs 0 while rst low (stalls forced 0).

## Timing
- Request seen in IDLE at cycle 0 → bus_en high cycle 1; ack in cycle k (k≥1) → stall low and rdata valid cycle k+1.
- Minimum: 2 stall cycles per access; back-to-back D then I with no IDLE gap.
- bus_* outputs are register-driven; no combinational path from requester inputs to bus.
- rdata holds until next completion for that requester or reset.
- No request granted in a cycle where its done flag is set; re-request after advance begins a new transaction.

## Test plan
- Reset: drive rst low with bus busy → bus_en, bus_err, stalls, rdata all 0 immediately; after release, state IDLE.
- Single fetch: if_ce=1, if_addr=0x100, ack in cycle 1 with 0x24010005 → bus_addr=0x100, bus_sel=1111 cycle 1; if_stall high cycles 0–1, low cycle 2, if_rdata=0x24010005; advance cycle 2 → no reissue.
- Contention: d_en load 0x200 and if_ce 0x104 same cycle, immediate acks (0xAAAA5555, 0x8C020000) → bus_addr 0x200 cycle 1, 0x104 cycle 2; d_stall low cycle 2 while if_stall high until cycle 3; both flags clear on advance.
- Store with wait states: d_we=1, d_sel=0011, d_addr=0x40, d_wdata=0xDEADBEEF, ack after 3 wait cycles → bus_we/sel/addr/wdata stable 4 cycles, d_stall low cycle 5, d_rdata unchanged.
- Watchdog: TIMEOUT=4, never ack → bus_en high 4 cycles then low, bus_err=1, if_rdata=0, if_stall released; clr_err → bus_err=0.
- Reset mid-transaction: rst low during BUSY_D wait state → bus_en 0 same cycle; after release with d_en still high, new transaction issued, address relatched.
